// File: rtl/mat_bias_relu_pkg.sv
// Shared linalg definitions: float constants, ReLU helper and the controller state encoding.
package mat_bias_relu_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0;

  localparam logic [2:0] GET_MAT  = 3'd0;
  localparam logic [2:0] GET_BIAS = 3'd1;
  localparam logic [2:0] ADD_IN   = 3'd2;
  localparam logic [2:0] ADD_OUT  = 3'd3;
  localparam logic [2:0] PUT_MAT  = 3'd4;

  // Any value with the sign bit set (including -0, -inf, negative NaN) clamps to +0.
  function automatic logic [31:0] relu_f32(input logic [31:0] z);
    return z[31] ? FP_ZERO : z;
  endfunction

endpackage

// File: rtl/mat_bias_relu_adder.sv
// Single-precision float adder with stb/ack operand and result ports; rounds to nearest even.
module mat_bias_relu_adder
  import mat_bias_relu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [1:0] StGetA = 2'd0;
  localparam logic [1:0] StGetB = 2'd1;
  localparam logic [1:0] StPut  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] a_q, a_d, z_q, z_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [23:0] mx, my;
    logic [26:0] ext, sh, lost;
    logic [27:0] s;
    logic [24:0] m;
    logic        rnd_up;
    int          ex, ey, d, e;
    if ((a[30:23] == 8'hff && a[22:0] != 23'd0) || (b[30:23] == 8'hff && b[22:0] != 23'd0)) begin
      return 32'hffc00000;
    end
    if (a[30:23] == 8'hff) return (b[30:23] == 8'hff && a[31] != b[31]) ? 32'hffc00000 : a;
    if (b[30:23] == 8'hff) return b;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return {a[31] & b[31], 31'd0};
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    mx = {x[30:23] != 8'd0, x[22:0]};
    my = {y[30:23] != 8'd0, y[22:0]};
    ex = (x[30:23] == 8'd0) ? 1 : int'({24'd0, x[30:23]});
    ey = (y[30:23] == 8'd0) ? 1 : int'({24'd0, y[30:23]});
    d  = ex - ey;
    // Three extra bits (guard, round, sticky) are enough for correct nearest-even rounding.
    ext = {my, 3'b000};
    if (d > 26) begin
      sh = {26'd0, |my};
    end else begin
      sh    = ext >> d;
      lost  = ext & ((27'd1 << d) - 27'd1);
      sh[0] = sh[0] | (|lost);
    end
    if (x[31] == y[31]) s = {1'b0, mx, 3'b000} + {1'b0, sh};
    else                s = {1'b0, mx, 3'b000} - {1'b0, sh};
    if (s == 28'd0) return FP_ZERO;
    e = ex;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26] && e > 1) begin
        s = s << 1;
        e = e - 1;
      end
    end
    rnd_up = s[2] & (s[1] | s[0] | s[3]);
    m = {1'b0, s[26:3]} + {24'd0, rnd_up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {x[31], 8'hff, 23'd0};
    return {x[31], m[23] ? 8'(e) : 8'd0, m[22:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    z_d     = z_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    z_stb_d = z_stb_q;
    case (state_q)
      StGetA: begin
        if (input_a_stb && a_ack_q) begin
          a_d     = input_a;
          state_d = StGetB;
        end else begin
          a_ack_d = 1'b1;
        end
      end
      StGetB: begin
        if (input_b_stb && b_ack_q) begin
          z_d     = fp_add(a_q, input_b);
          z_stb_d = 1'b1;
          state_d = StPut;
        end else begin
          b_ack_d = 1'b1;
        end
      end
      StPut: begin
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = StGetA;
        end
      end
      default: state_d = StGetA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StGetA;
      a_q     <= FP_ZERO;
      z_q     <= FP_ZERO;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      z_q     <= z_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
    end
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

endmodule

// File: rtl/mat_bias_relu.sv
// Adds a bias row to every row of an M x P float matrix and applies ReLU, using a batched adder pool.
module mat_bias_relu
  import mat_bias_relu_pkg::*;
#(
  parameter int unsigned M        = 1,
  parameter int unsigned P        = 1,
  parameter int unsigned N_ADDERS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [M-1:0][P-1:0][31:0]  input_mat,
  input  logic                       input_mat_stb,
  output logic                       input_mat_ack,
  input  logic [P-1:0][31:0]         input_bias,
  input  logic                       input_bias_stb,
  output logic                       input_bias_ack,
  output logic [M-1:0][P-1:0][31:0]  output_mat,
  output logic                       output_mat_stb,
  input  logic                       output_mat_ack
);

  localparam int unsigned Elems     = M * P;
  localparam int unsigned NBatches  = (Elems + N_ADDERS - 1) / N_ADDERS;
  localparam int unsigned BW        = $clog2(NBatches) + 1;
  localparam logic [BW-1:0] LastBatch = BW'(NBatches - 1);

  logic [2:0]                state_q, state_d;
  logic [BW-1:0]             batch_q, batch_d;
  logic [Elems-1:0][31:0]    mat_q, mat_d, res_q, res_d;
  logic [P-1:0][31:0]        bias_q, bias_d;
  logic                      mat_ack_q, mat_ack_d, bias_ack_q, bias_ack_d, out_stb_q, out_stb_d;
  logic [N_ADDERS-1:0]       a_done_q, a_done_d, b_done_q, b_done_d, z_done_q, z_done_d;
  logic [N_ADDERS-1:0]       z_ack_q, z_ack_d;
  logic [N_ADDERS-1:0]       a_stb, b_stb, a_ack, b_ack, z_stb, a_xfer, b_xfer, z_xfer;
  logic [N_ADDERS-1:0][31:0] lane_a, lane_b, lane_z;
  logic [N_ADDERS-1:0]       lane_live;
  int unsigned               lane_e [N_ADDERS];

  // Padding lanes past the last element add +0 + +0 and never match a result slot.
  always_comb begin
    lane_a    = '0;
    lane_b    = '0;
    lane_live = '0;
    lane_e    = '{default: 0};
    for (int unsigned l = 0; l < N_ADDERS; l++) begin
      lane_e[l]    = 32'(batch_q) * N_ADDERS + l;
      lane_live[l] = lane_e[l] < Elems;
      for (int unsigned k = 0; k < Elems; k++) begin
        if (lane_e[l] == k) lane_a[l] = mat_q[k];
      end
      for (int unsigned c = 0; c < P; c++) begin
        if (lane_live[l] && (lane_e[l] % P) == c) lane_b[l] = bias_q[c];
      end
    end
  end

  assign a_stb  = (state_q == ADD_IN) ? ~a_done_q : '0;
  assign b_stb  = (state_q == ADD_IN) ? ~b_done_q : '0;
  assign a_xfer = a_stb & a_ack;
  assign b_xfer = b_stb & b_ack;
  assign z_xfer = z_stb & z_ack_q;

  for (genvar l = 0; l < N_ADDERS; l++) begin : g_adder
    mat_bias_relu_adder u_adder (
      .clk          (clk),
      .rst          (rst),
      .input_a      (lane_a[l]),
      .input_a_stb  (a_stb[l]),
      .input_a_ack  (a_ack[l]),
      .input_b      (lane_b[l]),
      .input_b_stb  (b_stb[l]),
      .input_b_ack  (b_ack[l]),
      .output_z     (lane_z[l]),
      .output_z_stb (z_stb[l]),
      .output_z_ack (z_ack_q[l])
    );
  end

  always_comb begin
    state_d    = state_q;
    batch_d    = batch_q;
    mat_d      = mat_q;
    bias_d     = bias_q;
    res_d      = res_q;
    a_done_d   = a_done_q;
    b_done_d   = b_done_q;
    z_done_d   = z_done_q;
    z_ack_d    = '0;
    mat_ack_d  = 1'b0;
    bias_ack_d = 1'b0;
    out_stb_d  = out_stb_q;
    case (state_q)
      GET_MAT: begin
        if (input_mat_stb && mat_ack_q) begin
          mat_d   = input_mat;
          state_d = GET_BIAS;
        end else begin
          mat_ack_d = 1'b1;
        end
      end
      GET_BIAS: begin
        if (input_bias_stb && bias_ack_q) begin
          bias_d  = input_bias;
          state_d = ADD_IN;
        end else begin
          bias_ack_d = 1'b1;
        end
      end
      ADD_IN: begin
        a_done_d = a_done_q | a_xfer;
        b_done_d = b_done_q | b_xfer;
        if (&(a_done_d & b_done_d)) begin
          a_done_d = '0;
          b_done_d = '0;
          state_d  = ADD_OUT;
        end
      end
      ADD_OUT: begin
        z_done_d = z_done_q | z_xfer;
        z_ack_d  = ~z_done_d;
        for (int unsigned l = 0; l < N_ADDERS; l++) begin
          for (int unsigned k = 0; k < Elems; k++) begin
            if (z_xfer[l] && lane_e[l] == k) res_d[k] = relu_f32(lane_z[l]);
          end
        end
        if (&z_done_d) begin
          z_done_d = '0;
          z_ack_d  = '0;
          if (batch_q == LastBatch) begin
            batch_d   = '0;
            out_stb_d = 1'b1;
            state_d   = PUT_MAT;
          end else begin
            batch_d = batch_q + 1'b1;
            state_d = ADD_IN;
          end
        end
      end
      PUT_MAT: begin
        if (out_stb_q && output_mat_ack) begin
          out_stb_d = 1'b0;
          state_d   = GET_MAT;
        end
      end
      default: state_d = GET_MAT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= GET_MAT;
      batch_q    <= '0;
      mat_q      <= '0;
      bias_q     <= '0;
      res_q      <= '0;
      a_done_q   <= '0;
      b_done_q   <= '0;
      z_done_q   <= '0;
      z_ack_q    <= '0;
      mat_ack_q  <= 1'b0;
      bias_ack_q <= 1'b0;
      out_stb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      batch_q    <= batch_d;
      mat_q      <= mat_d;
      bias_q     <= bias_d;
      res_q      <= res_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
      z_done_q   <= z_done_d;
      z_ack_q    <= z_ack_d;
      mat_ack_q  <= mat_ack_d;
      bias_ack_q <= bias_ack_d;
      out_stb_q  <= out_stb_d;
    end
  end

  assign input_mat_ack  = mat_ack_q;
  assign input_bias_ack = bias_ack_q;
  assign output_mat     = res_q;
  assign output_mat_stb = out_stb_q;

endmodule

// File: tb/tb_mat_bias_relu.sv
// Randomised self-checking bench for mat_bias_relu with an exact dyadic-value reference model.
module tb_mat_bias_relu;
  import mat_bias_relu_pkg::*;

  localparam int unsigned M  = 2;
  localparam int unsigned P  = 3;
  localparam int unsigned NA = 4;

  typedef logic [M-1:0][P-1:0][31:0] mat_t;
  typedef logic [P-1:0][31:0]        bias_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  mat_t  input_mat = '0;
  logic  input_mat_stb = 1'b0;
  logic  input_mat_ack;
  bias_t input_bias = '0;
  logic  input_bias_stb = 1'b0;
  logic  input_bias_ack;
  mat_t  output_mat;
  logic  output_mat_stb;
  logic  output_mat_ack = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   bias_ack_cycles = 0;
  mat_t exp_q[$];

  always #5 clk = ~clk;

  mat_bias_relu #(.M(M), .P(P), .N_ADDERS(NA)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_mat      (input_mat),
    .input_mat_stb  (input_mat_stb),
    .input_mat_ack  (input_mat_ack),
    .input_bias     (input_bias),
    .input_bias_stb (input_bias_stb),
    .input_bias_ack (input_bias_ack),
    .output_mat     (output_mat),
    .output_mat_stb (output_mat_stb),
    .output_mat_ack (output_mat_ack)
  );

  task automatic check_val(input string name, input logic [M*P*32-1:0] act,
                           input logic [M*P*32-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Value k/16 encoded exactly as float32 (|k| < 2^24).
  function automatic logic [31:0] enc_k(input int k);
    int unsigned mag;
    int          p;
    logic [31:0] r;
    if (k == 0) return 32'h0;
    mag = (k < 0) ? -k : k;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    r[31]    = (k < 0);
    r[30:23] = 8'(127 + p - 4);
    r[22:0]  = 23'(mag << (23 - p));
    return r;
  endfunction

  function automatic int rnd_k();
    int v;
    v = int'($urandom_range(0, 2097152)) - 1048576;
    if ($urandom_range(0, 1) == 1) v = v / 16384;
    return v;
  endfunction

  function automatic mat_t mk(input logic [31:0] a00, a01, a02, a10, a11, a12);
    mat_t r;
    r[0][0] = a00; r[0][1] = a01; r[0][2] = a02;
    r[1][0] = a10; r[1][1] = a11; r[1][2] = a12;
    return r;
  endfunction

  function automatic bias_t mkb(input logic [31:0] b0, b1, b2);
    bias_t r;
    r[0] = b0; r[1] = b1; r[2] = b2;
    return r;
  endfunction

  // Compare process: every cycle the output is offered it must equal the oldest pending result.
  always @(negedge clk) begin
    if (rst) begin
      if (input_bias_ack) bias_ack_cycles++;
      check_val("no_input_ack_while_output", output_mat_stb && (input_mat_ack || input_bias_ack), 0);
      if (output_mat_stb) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h with no pending transaction", output_mat);
        end else begin
          check_val("output_mat", output_mat, exp_q[0]);
          if (output_mat_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_txn(input mat_t m, input bias_t b, input mat_t e, input int hold,
                         input bit abort);
    int n;
    int acks0;
    exp_q.push_back(e);
    acks0 = bias_ack_cycles;
    @(posedge clk); #1;
    input_mat = m;
    input_bias = b;
    input_mat_stb = 1'b1;
    input_bias_stb = 1'b1;
    n = 0;
    while (n < 100) begin @(negedge clk); if (input_mat_ack) break; n++; end
    check_val("mat_accept_in_time", n < 100, 1);
    check_val("bias_ack_low_in_get_mat", bias_ack_cycles - acks0, 0);
    @(posedge clk); #1;
    input_mat_stb = 1'b0;
    input_mat = {M*P{$urandom}};
    n = 0;
    while (n < 100) begin @(negedge clk); if (input_bias_ack) break; n++; end
    check_val("bias_accept_in_time", n < 100, 1);
    @(posedge clk); #1;
    input_bias_stb = 1'b0;
    input_bias = {P{$urandom}};
    if (abort) begin
      n = 0;
      while (n < 200 && dut.state_q != ADD_OUT) begin @(negedge clk); n++; end
      check_val("reach_add_out", n < 200, 1);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check_val("abort_mat_ack", input_mat_ack, 0);
      check_val("abort_bias_ack", input_bias_ack, 0);
      check_val("abort_out_stb", output_mat_stb, 0);
      check_val("abort_out_mat", output_mat, 0);
      void'(exp_q.pop_back());
      return;
    end
    n = 0;
    while (n < 400) begin @(negedge clk); if (output_mat_stb) break; n++; end
    check_val("output_in_time", n < 400, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_out_stb", output_mat_stb, 1);
      check_val("hold_no_mat_ack", input_mat_ack, 0);
    end
    @(posedge clk); #1 output_mat_ack = 1'b1;
    @(posedge clk); #1 output_mat_ack = 1'b0;
    @(negedge clk);
    check_val("out_stb_falls", output_mat_stb, 0);
    check_val("mat_ack_still_low", input_mat_ack, 0);
    @(negedge clk);
    check_val("mat_ack_rises", input_mat_ack, 1);
    check_val("bias_ack_once", bias_ack_cycles - acks0, 1);
  endtask

  task automatic rand_txn(input int hold, input bit abort);
    mat_t  m, e;
    bias_t b;
    int    kb [P];
    int    km, sum;
    for (int c = 0; c < P; c++) begin
      kb[c] = rnd_k();
      b[c]  = enc_k(kb[c]);
    end
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < P; c++) begin
        km = ($urandom_range(0, 7) == 0) ? -kb[c] : rnd_k();
        m[r][c] = enc_k(km);
        sum = km + kb[c];
        e[r][c] = (sum > 0) ? enc_k(sum) : 32'h0;
      end
    end
    run_txn(m, b, e, hold, abort);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_mat_ack", input_mat_ack, 0);
    check_val("reset_bias_ack", input_bias_ack, 0);
    check_val("reset_out_stb", output_mat_stb, 0);
    check_val("reset_out_mat", output_mat, 0);
    @(posedge clk); #1 rst = 1'b1;

    check_val("model_enc_1p0", enc_k(16), 32'h3F800000);
    check_val("model_enc_m3p0", enc_k(-48), 32'hC0400000);
    check_val("model_enc_0p5", enc_k(8), 32'h3F000000);
    check_val("model_enc_2p5", enc_k(40), 32'h40200000);

    // All-ones matrix with per-column bias, held under back-pressure for 20 cycles.
    run_txn(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
               32'h3F800000),
            mkb(32'hBF800000, 32'h3F800000, 32'h40000000),
            mk(32'h0, 32'h40000000, 32'h40400000, 32'h0, 32'h40000000, 32'h40400000), 20, 1'b0);
    // Sign-bit specials and nearest-even ties.
    run_txn(mk(32'h80000000, 32'hFF800000, 32'hFFC00000, 32'h7F800000, 32'h33800000,
               32'h34400000),
            mkb(32'h80000000, 32'h3F800000, 32'h3F800000),
            mk(32'h0, 32'h0, 32'h0, 32'h7F800000, 32'h3F800000, 32'h3F800002), 0, 1'b0);
    run_txn(mk(32'h3F800000, 32'hC0400000, 32'h0, 32'h3F800000, 32'hC0400000, 32'h0),
            mkb(32'h3F000000, 32'h40000000, 32'h3F800000),
            mk(32'h3FC00000, 32'h0, 32'h3F800000, 32'h3FC00000, 32'h0, 32'h3F800000), 1, 1'b0);

    for (int t = 0; t < 6; t++) rand_txn(int'($urandom_range(0, 3)), 1'b0);
    rand_txn(0, 1'b1);
    for (int t = 0; t < 4; t++) rand_txn(int'($urandom_range(0, 3)), 1'b0);

    check_val("no_pending_results", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_bias_relu.md
Name: mat_bias_relu

Overview:
- Downstream stage of the matrix-product block. Consumes the M x P float32 product matrix and a P-element float32 bias row.
- Adds the bias to every row, column-wise, then applies ReLU.
- Emits the M x P activation matrix to the next layer, or back to the next matrix-product stage.
- Uses the same stb/ack handshakes and a batched pool of single-precision adders.

Parameters:
- M, 1, rows of input/output matrix
- P, 1, columns of input/output matrix; length of bias vector
- N_ADDERS, 1, parallel float adders; elements processed per batch

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 on a rising clk edge resets)
- input_mat  in  [M-1:0][P-1:0][31:0]  product matrix, IEEE-754 single
- input_mat_stb  in  1  input_mat valid
- input_mat_ack  out  1  ready for input_mat
- input_bias  in  [P-1:0][31:0]  bias row
- input_bias_stb  in  1  input_bias valid
- input_bias_ack  out  1  ready for input_bias
- output_mat  out  [M-1:0][P-1:0][31:0]  activated matrix
- output_mat_stb  out  1  output_mat valid
- output_mat_ack  in  1  consumer accepts output_mat

Behaviour:
- Reset values:
  - input_mat_ack=0, input_bias_ack=0, output_mat_stb=0, output_mat=0.
  - State=GET_MAT, batch counter=0, all adder stb/ack/done flags=0.
- Reset mid-operation: the transaction is abandoned, with no partial output. After reset is released, the block restarts at GET_MAT.
- Handshake rule, all ports:
  - Transfer occurs on a clock edge where stb && ack.
  - Ack is registered: it rises the cycle after entering the accepting state and falls the cycle after a transfer.
  - output_mat and output_mat_stb hold stable until the transfer; output_mat_stb drops the cycle after output_mat_ack is seen.
- Constants:
  - N_BATCHES = ceil(M*P / N_ADDERS).
  - Element index e = batch*N_ADDERS + lane; row = e / P, col = e % P.
- States:
  - GET_MAT: assert input_mat_ack; on transfer, latch input_mat and go to GET_BIAS.
  - GET_BIAS: assert input_bias_ack; on transfer, latch input_bias and go to ADD_IN. Bias is re-fetched every transaction.
  - ADD_IN:
    - Per lane, drive a = mat[row][col] and b = bias[col], and raise a_stb/b_stb until each is acked. Per-lane done flags record each acceptance.
    - Lanes with e >= M*P feed +0.0 + +0.0; their result is discarded.
    - When all lanes have had both a and b accepted, clear the flags and go to ADD_OUT.
  - ADD_OUT:
    - Per lane, raise z_ack until the lane's z_stb && z_ack transfer.
    - On transfer, store relu(z) into result[e] when e < M*P.
    - When all lanes are done: if batch == N_BATCHES-1, reset batch to 0 and go to PUT_MAT; else increment batch and go to ADD_IN.
  - PUT_MAT: drive output_mat from the result buffer and assert output_mat_stb; on transfer, go to GET_MAT.
- ReLU: if bit31 == 1, output 32'h00000000; else pass z unchanged.
  - -0.0 becomes +0.0.
  - -inf and negative NaN become +0.0.
  - +inf and positive NaN pass through.
- Arithmetic: the adders round to nearest even, as in the team's float adder. This block performs no other arithmetic on data.
- Simultaneous events:
  - Stb presented on input_bias while in GET_MAT is ignored; input_bias_ack stays 0.
  - Producers may hold stb indefinitely; the block never accepts new input while in ADD_IN, ADD_OUT or PUT_MAT.
- Latency: determined by adder latency; at least N_BATCHES*(adder latency + 4) cycles from bias transfer to output_mat_stb.
- Batch counter width: $clog2(N_BATCHES)+1.

Decomposition:
- Shared linalg package:
  - localparam FP_ZERO = 32'h0
  - function relu_f32 (sign-bit test)
  - state enum {GET_MAT, GET_BIAS, ADD_IN, ADD_OUT, PUT_MAT} on 3 bits, matching the matrix-product encoding style
- Sub-module: the team's existing single-precision float adder with stb/ack ports (adder), instantiated N_ADDERS times in a generate loop. No new sub-module is needed.

Test Plan:
- M=1, P=2, N_ADDERS=1: mat={1.0 (3F800000), -3.0 (C0400000)}, bias={0.5 (3F000000), 2.0 (40000000)} -> output {1.5 (3FC00000), 0 (00000000)}.
- M=2, P=3, N_ADDERS=4 (2 batches, 2 idle lanes): mat all 1.0, bias={-1.0, 1.0, 2.0} -> rows {00000000, 40000000, 40400000} twice; padded lanes never write out of bounds.
- ReLU edge cases: z = -0.0, -inf (FF800000), negative NaN (FFC00000), +inf (7F800000) -> 00000000, 00000000, 00000000, 7F800000.
- Back-pressure: hold output_mat_ack=0 for 20 cycles -> output_mat_stb and output_mat stay constant, no new input_mat_ack; ack=1 -> stb falls the next cycle and input_mat_ack rises the following cycle.
- Reset mid ADD_OUT (rst=0 for 1 cycle) -> all outputs at reset values the next cycle; a following full transaction yields correct results with no residue from the aborted one.
- Two back-to-back transactions with different biases -> the second output uses only the second bias; input_bias_ack asserts exactly once per transaction.
